// File: rtl/nonconsec_rep_checker.sv
// Synthesizable monitor for the property a |-> b[=REP_N] ##1 c.
// One attempt at a time; registered pass/fail pulses, fail cause and saturating statistics.
module nonconsec_rep_checker #(
    parameter int unsigned REP_N    = 3,
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned BW      = $clog2(REP_N + 1),
    localparam int unsigned WW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_cnt_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    output logic             busy_o,
    output logic [BW-1:0]    b_cnt_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [1:0]       fail_code_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_WAIT_C = 2'd2;

    localparam logic [1:0] CODE_EXTRA_B = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    logic [1:0]    state, nxt_state;
    logic [BW-1:0] b_cnt, nxt_cnt;
    logic [WW-1:0] wait_cnt, nxt_wait;
    logic          pass_d, fail_d, drop_d;
    logic [1:0]    code_d;
    logic          busy;

    assign busy = (state == S_COUNT) || (state == S_WAIT_C);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = b_cnt;
        nxt_wait  = wait_cnt;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        drop_d    = 1'b0;
        code_d    = fail_code_o;
        if (!en_i) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            nxt_wait  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_i) begin
                        nxt_wait  = WW'(1);
                        nxt_cnt   = b_i ? BW'(1) : '0;
                        nxt_state = (b_i && REP_N == 1) ? S_WAIT_C : S_COUNT;
                    end
                end
                S_COUNT: begin
                    drop_d = a_i;
                    if (b_i) begin
                        nxt_cnt = b_cnt + 1'b1;
                        if (b_cnt + 1'b1 == BW'(REP_N))
                            nxt_state = S_WAIT_C;
                    end
                end
                S_WAIT_C: begin
                    drop_d = a_i;
                    if (c_i) begin
                        pass_d    = 1'b1;
                        nxt_state = S_IDLE;
                    end else if (b_i) begin
                        fail_d    = 1'b1;
                        code_d    = CODE_EXTRA_B;
                        nxt_state = S_IDLE;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
            // A pass/fail decided on the same edge takes priority over the timeout.
            if (MAX_WAIT > 0 && busy && !pass_d && !fail_d) begin
                if (wait_cnt == WW'(MAX_WAIT)) begin
                    fail_d    = 1'b1;
                    code_d    = CODE_TIMEOUT;
                    nxt_state = S_IDLE;
                end else begin
                    nxt_wait = wait_cnt + 1'b1;
                end
            end
            if (nxt_state == S_IDLE) begin
                nxt_cnt  = '0;
                nxt_wait = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            b_cnt       <= '0;
            wait_cnt    <= '0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_code_o <= '0;
        end else begin
            state       <= nxt_state;
            b_cnt       <= nxt_cnt;
            wait_cnt    <= nxt_wait;
            pass_o      <= pass_d;
            fail_o      <= fail_d;
            fail_code_o <= code_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (pass_d && pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + 1'b1;
            if (fail_d && fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + 1'b1;
            if (drop_d && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    assign busy_o  = busy;
    assign b_cnt_o = b_cnt;

endmodule

// File: tb/tb_nonconsec_rep_checker.sv
// Directed bench for nonconsec_rep_checker: unbounded instance (CNT_W=16) and
// bounded instance (MAX_WAIT=8, CNT_W=2) share the same stimulus.
module tb_nonconsec_rep_checker;

    logic clk = 1'b0;
    logic rst_n, en_i, clr_cnt_i, a_i, b_i, c_i;

    logic        busy0, pass0, fail0;
    logic [1:0]  bcnt0, code0;
    logic [15:0] pcnt0, fcnt0, dcnt0;

    logic        busy8, pass8, fail8;
    logic [1:0]  bcnt8, code8;
    logic [1:0]  pcnt8, fcnt8, dcnt8;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic        saw_fail0;

    always #5 clk = ~clk;

    nonconsec_rep_checker #(.REP_N(3), .MAX_WAIT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_cnt_i(clr_cnt_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .busy_o(busy0), .b_cnt_o(bcnt0), .pass_o(pass0), .fail_o(fail0),
        .fail_code_o(code0), .pass_cnt_o(pcnt0), .fail_cnt_o(fcnt0), .drop_cnt_o(dcnt0)
    );

    nonconsec_rep_checker #(.REP_N(3), .MAX_WAIT(8), .CNT_W(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_cnt_i(clr_cnt_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .busy_o(busy8), .b_cnt_o(bcnt8), .pass_o(pass8), .fail_o(fail8),
        .fail_code_o(code8), .pass_cnt_o(pcnt8), .fail_cnt_o(fcnt8), .drop_cnt_o(dcnt8)
    );

    // One sample edge; outputs are observed 1 time unit after it.
    task automatic step(input logic a, input logic b, input logic c);
        a_i = a; b_i = b; c_i = c;
        @(posedge clk);
        #1;
        saw_fail0 = saw_fail0 | fail0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en_i = 1'b1; clr_cnt_i = 1'b0;
        a_i = 1'b0; b_i = 1'b0; c_i = 1'b0;
        saw_fail0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic full_pass();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy0, bcnt0, pass0, fail0, code0} !== 7'b0)
            $display("FAIL reset_flags got=%b want=0", {busy0, bcnt0, pass0, fail0, code0});
        else passed++;
        total++;
        if ({pcnt0, fcnt0, dcnt0} !== 48'b0)
            $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", pcnt0, fcnt0, dcnt0);
        else passed++;
    endtask

    task automatic test_basic_pass();
        do_reset();
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
        total++;
        if (busy0 !== 1'b1 || bcnt0 !== 2'd3)
            $display("FAIL basic_count busy=%b cnt=%0d want busy=1 cnt=3", busy0, bcnt0);
        else passed++;
        step(0, 0, 0);
        total++;
        if (pass0 !== 1'b0) $display("FAIL basic_early_pass got=%b want=0", pass0);
        else passed++;
        step(0, 0, 1);
        total++;
        if (pass0 !== 1'b1 || pcnt0 !== 16'd1 || busy0 !== 1'b0)
            $display("FAIL basic_pass pass=%b cnt=%0d busy=%b want 1/1/0", pass0, pcnt0, busy0);
        else passed++;
        step(0, 0, 0);
        total++;
        if (pass0 !== 1'b0 || saw_fail0 !== 1'b0)
            $display("FAIL basic_pulse pass=%b saw_fail=%b want 0/0", pass0, saw_fail0);
        else passed++;
    endtask

    task automatic test_extra_b();
        do_reset();
        step(1, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
        total++;
        if (fail0 !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL extra_b_wait fail=%b busy=%b want 0/1", fail0, busy0);
        else passed++;
        step(0, 1, 0);
        total++;
        if (fail0 !== 1'b1 || code0 !== 2'b01 || fcnt0 !== 16'd1 || pass0 !== 1'b0)
            $display("FAIL extra_b fail=%b code=%b fcnt=%0d pass=%b want 1/01/1/0",
                     fail0, code0, fcnt0, pass0);
        else passed++;
        step(0, 0, 0);
        total++;
        if (fail0 !== 1'b0 || code0 !== 2'b01)
            $display("FAIL extra_b_hold fail=%b code=%b want 0/01", fail0, code0);
        else passed++;
    endtask

    task automatic test_c_same_edge();
        do_reset();
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 1);
        total++;
        if (pass0 !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL c_same_edge pass=%b busy=%b want 0/1", pass0, busy0);
        else passed++;
        step(0, 0, 1);
        total++;
        if (pass0 !== 1'b1) $display("FAIL c_next_edge pass=%b want 1", pass0);
        else passed++;
    endtask

    task automatic test_c_beats_b();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
        total++;
        if (pass0 !== 1'b1 || fail0 !== 1'b0)
            $display("FAIL c_priority pass=%b fail=%b want 1/0", pass0, fail0);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 0, 0); step(0, 1, 0);
        for (int i = 3; i <= 8; i++) step(0, 0, 0);
        total++;
        if (fail8 !== 1'b0 || busy8 !== 1'b1)
            $display("FAIL timeout_early fail=%b busy=%b want 0/1", fail8, busy8);
        else passed++;
        step(0, 0, 0);
        total++;
        if (fail8 !== 1'b1 || code8 !== 2'b10 || busy8 !== 1'b0 || fcnt8 !== 2'd1)
            $display("FAIL timeout fail=%b code=%b busy=%b fcnt=%0d want 1/10/0/1",
                     fail8, code8, busy8, fcnt8);
        else passed++;
        total++;
        if (busy0 !== 1'b1 || fail0 !== 1'b0)
            $display("FAIL unbounded_wait busy=%b fail=%b want 1/0", busy0, fail0);
        else passed++;
    endtask

    task automatic test_drop();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); step(0, 0, 1);
        total++;
        if (pass0 !== 1'b1 || pcnt0 !== 16'd1 || dcnt0 !== 16'd1)
            $display("FAIL drop pass=%b pcnt=%0d dcnt=%0d want 1/1/1", pass0, pcnt0, dcnt0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 1);
        total++;
        if (pass0 !== 1'b1 || dcnt0 !== 16'd1 || busy0 !== 1'b0)
            $display("FAIL b2b_decide pass=%b dcnt=%0d busy=%b want 1/1/0", pass0, dcnt0, busy0);
        else passed++;
        step(1, 1, 0);
        total++;
        if (busy0 !== 1'b1 || bcnt0 !== 2'd1 || pass0 !== 1'b0)
            $display("FAIL b2b_restart busy=%b cnt=%0d pass=%b want 1/1/0", busy0, bcnt0, pass0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        full_pass();
        step(1, 1, 0); step(0, 1, 0);
        rst_n = 1'b0;
        #2;
        total++;
        if (busy0 !== 1'b0 || bcnt0 !== 2'd0 || pcnt0 !== 16'd0 || pass0 !== 1'b0)
            $display("FAIL reset_mid busy=%b cnt=%0d pcnt=%0d pass=%b want 0/0/0/0",
                     busy0, bcnt0, pcnt0, pass0);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0); step(0, 0, 1);
        total++;
        if (pass0 !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL reset_mid_after pass=%b busy=%b want 0/0", pass0, busy0);
        else passed++;
    endtask

    task automatic test_enable();
        do_reset();
        full_pass();
        step(1, 1, 0);
        en_i = 1'b0;
        step(0, 1, 0);
        total++;
        if (busy0 !== 1'b0 || bcnt0 !== 2'd0)
            $display("FAIL en_low busy=%b cnt=%0d want 0/0", busy0, bcnt0);
        else passed++;
        step(1, 1, 0);
        en_i = 1'b1;
        step(0, 1, 0); step(0, 0, 1);
        total++;
        if (pass0 !== 1'b0 || busy0 !== 1'b0 || pcnt0 !== 16'd1 || dcnt0 !== 16'd0 ||
            saw_fail0 !== 1'b0)
            $display("FAIL en_resume pass=%b busy=%b pcnt=%0d dcnt=%0d fail=%b want 0/0/1/0/0",
                     pass0, busy0, pcnt0, dcnt0, saw_fail0);
        else passed++;
    endtask

    task automatic test_clear_and_saturate();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
        clr_cnt_i = 1'b1;
        step(0, 0, 1);
        clr_cnt_i = 1'b0;
        total++;
        if (pass0 !== 1'b1 || pcnt0 !== 16'd0)
            $display("FAIL clear_wins pass=%b pcnt=%0d want 1/0", pass0, pcnt0);
        else passed++;
        for (int i = 0; i < 4; i++) full_pass();
        total++;
        if (pcnt8 !== 2'd3 || pcnt0 !== 16'd4)
            $display("FAIL saturate pcnt8=%0d pcnt0=%0d want 3/4", pcnt8, pcnt0);
        else passed++;
        clr_cnt_i = 1'b1;
        step(0, 0, 0);
        clr_cnt_i = 1'b0;
        total++;
        if (pcnt8 !== 2'd0 || pcnt0 !== 16'd0)
            $display("FAIL clear pcnt8=%0d pcnt0=%0d want 0/0", pcnt8, pcnt0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_extra_b();
        test_c_same_edge();
        test_c_beats_b();
        test_timeout();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_clear_and_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
